iccm_dump_tx: RTL and testbench



---
 rtl/prog_pkg.sv | 6 +
 rtl/uart_tx_byte.sv | 59 +++++
 rtl/iccm_dump_tx.sv | 89 ++++++++
 tb/tb_iccm_dump_tx.sv | 137 +++++++++++++
 4 files changed

// File: rtl/prog_pkg.sv
// prog_pkg: shared types and constants for the ICCM programming and dump paths
package prog_pkg;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, SEND, DONE} dump_state_e;
  localparam int UART_FRAME_BITS = 10;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 transmitter whose start bit begins in the accept cycle, allowing gapless frames
module uart_tx_byte
  import prog_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [7:0]  data_i,
  input  logic [15:0] cpb_i,
  output logic        tx_o,
  output logic        frame_done_o
);
  logic        busy_q, busy_d;
  logic [9:0]  frame_q, frame_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] cnt_q, cnt_d;
  logic        last;
  logic        one;
  assign one = cpb_i <= 16'd1;
  assign last = cnt_q == 16'd0 && bit_q == 4'(UART_FRAME_BITS - 1);
  assign ready_o = !busy_q;
  assign frame_done_o = busy_q && last;
  assign tx_o = busy_q ? frame_q[0] : !valid_i;
  // accept cycle already counts as the first start-bit cycle
  always_comb begin
    busy_d = busy_q;
    frame_d = frame_q;
    bit_d = bit_q;
    cnt_d = cnt_q;
    if (!busy_q) begin
      if (valid_i) begin
        busy_d = 1'b1;
        frame_d = one ? {2'b11, data_i} : {1'b1, data_i, 1'b0};
        bit_d = one ? 4'd1 : 4'd0;
        cnt_d = one ? 16'd0 : cpb_i - 16'd2;
      end
    end else if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
    else if (last) busy_d = 1'b0;
    else begin
      bit_d = bit_q + 4'd1;
      frame_d = {1'b1, frame_q[9:1]};
      cnt_d = cpb_i - 16'd1;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      frame_q <= '1;
      bit_q <= '0;
      cnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      frame_q <= frame_d;
      bit_q <= bit_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/iccm_dump_tx.sv
// iccm_dump_tx: reads N ICCM words and sends each as four UART bytes, LSB first
module iccm_dump_tx
  import prog_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   word_count_i,
  input  logic [15:0]       clks_per_bit_i,
  output logic              csb_o,
  output logic              web_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);
  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [15:0]       cpb_q, cpb_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [1:0]        idx_q, idx_d;
  logic              u_valid, u_ready, u_done;
  assign u_valid = state_q == SEND && u_ready;
  assign csb_o = state_q != RD_REQ;
  assign web_o = 1'b1;
  assign addr_o = addr_q;
  assign busy_o = state_q == RD_REQ || state_q == RD_WAIT || state_q == SEND;
  assign done_o = state_q == DONE;
  uart_tx_byte u_tx (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(u_valid), .ready_o(u_ready),
    .data_i(word_q[7:0]), .cpb_i(cpb_q), .tx_o(tx_o), .frame_done_o(u_done)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    cpb_d = cpb_q;
    word_d = word_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: if (start_i) begin
        addr_d = base_addr_i;
        cnt_d = word_count_i;
        cpb_d = clks_per_bit_i == 16'd0 ? 16'd1 : clks_per_bit_i;
        state_d = word_count_i == '0 ? DONE : RD_REQ;
      end
      RD_REQ: state_d = RD_WAIT;
      RD_WAIT: begin
        word_d = rdata_i;
        idx_d = 2'd0;
        state_d = SEND;
      end
      SEND: if (u_done) begin
        word_d = word_q >> 8;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'(BYTES_PER_WORD - 1)) begin
          cnt_d = cnt_q - (ADDR_W+1)'(1);
          addr_d = addr_q + ADDR_W'(1);
          state_d = cnt_q == (ADDR_W+1)'(1) ? DONE : RD_REQ;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q <= '0;
      cnt_q <= '0;
      cpb_q <= 16'd1;
      word_q <= '0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      cpb_q <= cpb_d;
      word_q <= word_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: tb/tb_iccm_dump_tx.sv
// tb_iccm_dump_tx: directed checks of the ICCM dump transmitter against a cycle-level UART model
module tb_iccm_dump_tx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] word_count = '0;
  logic [15:0] cpb = '0;
  logic        csb, web, tx, busy, done;
  logic [9:0]  addr;
  logic [31:0] rdata = '0;
  logic [31:0] mem [0:1023];
  logic        tx_l [0:299];
  logic        csb_l [0:299];
  logic        done_l [0:299];
  logic        busy_l [0:299];
  logic [9:0]  addr_l [0:299];
  int n_chk = 0;
  int n_fail = 0;
  logic [9:0] f81 = 10'b1100000010;

  iccm_dump_tx dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base_addr),
    .word_count_i(word_count), .clks_per_bit_i(cpb), .csb_o(csb), .web_o(web),
    .addr_o(addr), .rdata_i(rdata), .tx_o(tx), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (!csb) rdata <= mem[addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_tx(input int t, input logic [9:0] b, input int n, input int ce);
    int rel, per, k, r, by, bi;
    logic [31:0] w;
    if (t < 3) return 1'b1;
    per = 40 * ce + 2;
    rel = t - 3;
    k = rel / per;
    r = rel % per;
    if (k >= n || r >= 40 * ce) return 1'b1;
    by = r / (10 * ce);
    bi = (r % (10 * ce)) / ce;
    if (bi == 0) return 1'b0;
    if (bi == 9) return 1'b1;
    w = mem[b + 10'(k)];
    return w[8 * by + bi - 1];
  endfunction

  task automatic run(input logic [9:0] b, input logic [10:0] n, input logic [15:0] c,
                     input int len, input int restart_at, input int exp_done);
    int ce, per, mism, dc, dn, csbn, addr_bad, web_bad;
    logic [9:0] ea;
    ce = (c == 16'd0) ? 1 : int'(c);
    per = 40 * ce + 2;
    mism = 0; dc = -1; dn = 0; csbn = 0; addr_bad = 0; web_bad = 0;
    @(negedge clk);
    base_addr = b; word_count = n; cpb = c; start = 1'b1;
    for (int i = 1; i < len; i++) begin
      @(negedge clk);
      start = (restart_at != 0 && i == restart_at);
      if (i == restart_at) begin
        base_addr = b + 10'd100; word_count = 11'd5; cpb = 16'd7;
      end
      tx_l[i] = tx; csb_l[i] = csb; addr_l[i] = addr;
      done_l[i] = done; busy_l[i] = busy;
      if (!web) web_bad++;
    end
    for (int i = 1; i < len; i++) begin
      if (done_l[i]) begin
        dn++;
        if (dc < 0) dc = i;
      end
      if (tx_l[i] !== exp_tx(i, b, int'(n), ce)) mism++;
      if (!csb_l[i]) begin
        csbn++;
        ea = b + 10'((i - 1) / per);
        if ((i - 1) % per != 0 || addr_l[i] !== ea) addr_bad++;
      end
    end
    chk("done_cycle", dc, exp_done);
    chk("done_pulses", dn, 1);
    chk("busy_at_done", busy_l[exp_done], 0);
    chk("busy_cycle1", busy_l[1], n != 0);
    chk("sram_reads", csbn, n);
    chk("read_addr_errs", addr_bad, 0);
    chk("tx_trace_errs", mism, 0);
    chk("web_low_cycles", web_bad, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h9E3779B9 * i + 32'h1234;
    mem[0] = 32'hA53C0F81;
    mem[1] = 32'h5AF00FC3;
    mem[5] = 32'h00000000;
    mem[1022] = 32'h12345678;
    mem[1023] = 32'hDEADBEEF;
    #3;
    chk("rst_csb", csb, 1); chk("rst_web", web, 1); chk("rst_addr", addr, 0);
    chk("rst_tx", tx, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    run(10'd0, 11'd1, 16'd4, 170, 0, 163);
    chk("csb_c1_addr", {csb_l[1], addr_l[1]}, 11'd0);
    for (int j = 0; j < 10; j++) chk("frame81_bit", tx_l[3 + 4 * j], f81[j]);
    chk("byte1_start", tx_l[43], 0);
    run(10'd1022, 11'd3, 16'd2, 255, 0, 247);
    chk("word_gap", {tx_l[82], tx_l[83], tx_l[84], tx_l[85]}, 4'b1110);
    chk("wrap_read", {csb_l[165], addr_l[165]}, 11'd0);
    run(10'd0, 11'd0, 16'd4, 20, 0, 1);
    run(10'd0, 11'd2, 16'd0, 95, 0, 85);
    run(10'd0, 11'd2, 16'd2, 175, 30, 165);
    @(negedge clk);
    base_addr = 10'd5; word_count = 11'd1; cpb = 16'd4; start = 1'b1;
    for (int i = 1; i <= 104; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_tx", tx, 0);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx", tx, 1); chk("async_rst_csb", csb, 1);
    chk("async_rst_busy", busy, 0); chk("async_rst_done", done, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    run(10'd1022, 11'd1, 16'd1, 60, 0, 43);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
